// File: rtl/out_channel_fifo.sv
// out_channel_fifo
// First-word-fall-through FIFO between the program interpreter's out channel
// and a downstream consumer. Once the interpreter reports finished, the FIFO
// stops accepting words, lets the consumer empty it, and then reports drained.
module out_channel_fifo #(
  parameter int DATA_WIDTH  = 12,
  parameter int DEPTH       = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_valid,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     wr_ready,
  input  logic                     prog_finished,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic [COUNT_WIDTH-1:0]   words_sent,
  output logic                     overflow,
  output logic                     drained
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic [AW-1:0]           rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0]           wr_ptr_reg, wr_ptr_next;
  logic [AW:0]             count_reg, count_next;
  logic [COUNT_WIDTH-1:0]  words_sent_reg, words_sent_next;
  logic                    overflow_reg, overflow_next;

  logic                    in_run;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;

  // Storage array. Read is asynchronous so the head word is visible the
  // cycle after it is written (fall-through); contents are never cleared.
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  assign full  = (count_reg == FULL_COUNT);
  assign empty = (count_reg == '0);

  // wr_ready only looks at registered state, so a pop from a full FIFO
  // cannot open a slot for a push in the same cycle.
  assign push = wr_valid && wr_ready;
  assign pop  = out_valid && out_ready;

  // State register: FSM state and all datapath registers, reset wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= ST_RUN;
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      count_reg      <= '0;
      words_sent_reg <= '0;
      overflow_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      rd_ptr_reg     <= rd_ptr_next;
      wr_ptr_reg     <= wr_ptr_next;
      count_reg      <= count_next;
      words_sent_reg <= words_sent_next;
      overflow_reg   <= overflow_next;
    end
  end

  // Next-state logic: RUN until finished, DRAIN until empty, DONE forever.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN: begin
        // A push accepted in this same cycle is still stored.
        if (prog_finished) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (empty && !push) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_DONE;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // FSM outputs: only RUN accepts words; DONE is reported as drained.
  always_comb begin
    in_run   = (state_reg == ST_RUN);
    wr_ready = in_run && !full;
    drained  = (state_reg == ST_DONE);
  end

  // Datapath next values: pointers, occupancy, pop counter, sticky overflow.
  always_comb begin
    rd_ptr_next     = rd_ptr_reg;
    wr_ptr_next     = wr_ptr_reg;
    count_next      = count_reg;
    words_sent_next = words_sent_reg;
    overflow_next   = overflow_reg;

    // Pointers wrap naturally because DEPTH is a power of two.
    if (push) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    if (pop) begin
      rd_ptr_next     = rd_ptr_reg + 1'b1;
      words_sent_next = words_sent_reg + 1'b1;
    end

    // push needs !full and pop needs !empty, so count stays in 0..DEPTH.
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase

    // A word offered while full in RUN is lost; remember that until reset.
    // Offers in DRAIN/DONE are simply ignored and do not count as overflow.
    if (wr_valid && in_run && full) begin
      overflow_next = 1'b1;
    end
  end

  // Buffer write port; suppressed during reset so a discarded word never lands.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Output drive: head word falls through whenever the FIFO is non-empty.
  always_comb begin
    out_valid  = !empty;
    out_data   = mem[rd_ptr_reg];
    count      = count_reg;
    words_sent = words_sent_reg;
    overflow   = overflow_reg;
  end

endmodule

// File: tb/tb_out_channel_fifo.sv
// tb_out_channel_fifo
// Directed stimulus against a queue-based model of the out-channel FIFO,
// compared on every falling edge, plus literal expectations per scenario.
module tb_out_channel_fifo;

  localparam int DW    = 12;
  localparam int DEPTH = 8;
  localparam int CWID  = 16;
  localparam int CNTW  = $clog2(DEPTH) + 1;

  logic            clock = 1'b0;
  logic            reset;
  logic            wr_valid;
  logic [DW-1:0]   wr_data;
  logic            wr_ready;
  logic            prog_finished;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_ready;
  logic [CNTW-1:0] count;
  logic [CWID-1:0] words_sent;
  logic            overflow;
  logic            drained;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  always #5 clock = ~clock;

  out_channel_fifo #(
    .DATA_WIDTH  (DW),
    .DEPTH       (DEPTH),
    .COUNT_WIDTH (CWID)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .wr_valid      (wr_valid),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .prog_finished (prog_finished),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .count         (count),
    .words_sent    (words_sent),
    .overflow      (overflow),
    .drained       (drained)
  );

  // Model: a queue of words, a phase (0 run, 1 drain, 2 done), pop count, sticky flag.
  int mq[$];
  int m_phase = 0;
  int m_sent  = 0;
  bit m_ovf   = 1'b0;

  always @(posedge clock) begin
    int  pre;
    bit  acc_push;
    bit  acc_pop;
    if (reset) begin
      mq.delete();
      m_phase = 0;
      m_sent  = 0;
      m_ovf   = 1'b0;
    end else begin
      pre      = mq.size();
      acc_push = wr_valid && (m_phase == 0) && (pre < DEPTH);
      acc_pop  = out_ready && (pre > 0);
      if (wr_valid && (m_phase == 0) && (pre == DEPTH)) m_ovf = 1'b1;
      if (acc_pop) begin
        void'(mq.pop_front());
        m_sent = (m_sent + 1) % (1 << CWID);
      end
      if (acc_push) mq.push_back(int'(wr_data));
      if (m_phase == 0 && prog_finished) m_phase = 1;
      else if (m_phase == 1 && pre == 0 && !acc_push) m_phase = 2;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    if (check_en) begin
      chk("m_count", 32'(count), 32'(mq.size()));
      chk("m_out_valid", 32'(out_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) chk("m_out_data", 32'(out_data), 32'(mq[0]));
      chk("m_wr_ready", 32'(wr_ready), 32'((m_phase == 0) && (mq.size() < DEPTH)));
      chk("m_words_sent", 32'(words_sent), 32'(m_sent));
      chk("m_overflow", 32'(overflow), 32'(m_ovf));
      chk("m_drained", 32'(drained), 32'(m_phase == 2));
    end
  end

  task automatic step(input bit r, input bit wv, input int wd, input bit pf, input bit ordy);
    reset         = r;
    wr_valid      = wv;
    wr_data       = DW'(wd);
    prog_finished = pf;
    out_ready     = ordy;
    @(posedge clock);
    #1;
    $display("cyc t=%0t rst=%0b wv=%0b wd=%0d pf=%0b ordy=%0b -> cnt=%0d ov=%0b od=%0d wr=%0b sent=%0d ovf=%0b drn=%0b",
             $time, r, wv, wd, pf, ordy, count, out_valid, out_data, wr_ready, words_sent, overflow, drained);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    step(1, 0, 0, 0, 0);
    step(1, 1, 3, 1, 1);
    check_en = 1'b1;
    step(0, 0, 0, 0, 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_wr_ready", 32'(wr_ready), 1);
    chk("rst_drained", 32'(drained), 0);
    chk("rst_overflow", 32'(overflow), 0);

    // Single word fall-through then pop.
    step(0, 1, 2, 0, 0);
    chk("t1_out_valid", 32'(out_valid), 1);
    chk("t1_out_data", 32'(out_data), 2);
    chk("t1_count", 32'(count), 1);
    step(0, 0, 0, 0, 1);
    chk("t1_count_after_pop", 32'(count), 0);
    chk("t1_words_sent", 32'(words_sent), 1);

    // Overfill by one, then drain in order.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      step(0, 1, 16 + i, 0, 0);
      if (i == 7) chk("t2_wr_ready_full", 32'(wr_ready), 0);
    end
    chk("t2_count_full", 32'(count), 8);
    chk("t2_overflow", 32'(overflow), 1);
    for (int i = 0; i < 8; i++) begin
      chk("t2_drain_data", 32'(out_data), 32'(16 + i));
      step(0, 0, 0, 0, 1);
    end
    chk("t2_empty", 32'(count), 0);

    // Steady push+pop across pointer wrap.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 100 + i, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 103 + i, 0, 1);
      chk("t3_count_steady", 32'(count), 3);
    end
    chk("t3_words_sent", 32'(words_sent), 20);
    chk("t3_head", 32'(out_data), 120);

    // Push in the finishing cycle, ignore later writes, drain to done.
    step(1, 0, 0, 0, 0);
    step(0, 1, 7, 0, 0);
    step(0, 1, 8, 1, 0);
    chk("t4_count_both", 32'(count), 2);
    chk("t4_wr_ready_drain", 32'(wr_ready), 0);
    step(0, 1, 9, 0, 0);
    chk("t4_ignored", 32'(count), 2);
    chk("t4_no_overflow", 32'(overflow), 0);
    chk("t4_head0", 32'(out_data), 7);
    step(0, 1, 10, 0, 1);
    chk("t4_head1", 32'(out_data), 8);
    step(0, 0, 0, 0, 1);
    chk("t4_not_yet_drained", 32'(drained), 0);
    for (int i = 0; i < 4 && drained !== 1'b1; i++) step(0, 1, 11, 0, 1);
    chk("t4_drained", 32'(drained), 1);
    step(0, 1, 12, 1, 1);
    chk("t4_done_sticky", 32'(drained), 1);
    chk("t4_done_count", 32'(count), 0);

    // Reset in DRAIN discards the queue and clears everything.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 1, 200 + i, 0, 0);
    step(0, 1, 300, 0, 1);
    chk("t5_full_pop_no_push", 32'(count), 7);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("t5_count_drain", 32'(count), 4);
    chk("t5_overflow_set", 32'(overflow), 1);
    step(1, 1, 5, 1, 1);
    chk("t5_rst_count", 32'(count), 0);
    chk("t5_rst_out_valid", 32'(out_valid), 0);
    chk("t5_rst_drained", 32'(drained), 0);
    chk("t5_rst_wr_ready", 32'(wr_ready), 1);
    chk("t5_rst_overflow", 32'(overflow), 0);
    chk("t5_rst_words_sent", 32'(words_sent), 0);
    step(0, 1, 42, 0, 0);
    chk("t5_fresh_head", 32'(out_data), 42);
    chk("t5_fresh_count", 32'(count), 1);
    step(0, 0, 0, 0, 0);

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
